// File: rtl/team_06_clkmeasure_if.sv
// team_06_clkmeasure_if: control and result signals of the period/duty measurement block
interface team_06_clkmeasure_if #(parameter int WIDTH = 16);
  logic             en;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;
  modport master(output en, sig_in, input period, high_time, valid, locked, timeout);
  modport slave(input en, sig_in, output period, high_time, valid, locked, timeout);
endinterface

// File: rtl/team_06_clkmeasure.sv
// team_06_clkmeasure: recovers period and high time of a slow square wave in clk cycles
module team_06_clkmeasure #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  nrst,
  team_06_clkmeasure_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t           state;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt, hcnt, hold_high;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  // two-flop synchronizer plus one extra stage for edge detection
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {bus.sig_in, s1, s2};
  // measurement FSM; disable takes priority over every edge and over timeout
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      cnt           <= '0;
      hcnt          <= '0;
      hold_high     <= '0;
      bus.period    <= '0;
      bus.high_time <= '0;
      bus.valid     <= 1'b0;
      bus.locked    <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (!bus.en) begin
        state      <= IDLE;
        cnt        <= '0;
        hcnt       <= '0;
        bus.locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM:
            if (rise) begin
              cnt   <= ONE;
              hcnt  <= ONE;
              state <= MEASURE;
            end
          default:
            if (rise) begin
              bus.period    <= cnt;
              bus.high_time <= hold_high;
              bus.valid     <= 1'b1;
              bus.locked    <= 1'b1;
              bus.timeout   <= 1'b0;
              cnt           <= ONE;
              hcnt          <= ONE;
            end else if (cnt == MAX) begin
              bus.timeout <= 1'b1;
              bus.locked  <= 1'b0;
              cnt         <= '0;
              hcnt        <= '0;
              state       <= ARM;
            end else begin
              cnt <= cnt + ONE;
              if (s2 && hcnt != MAX) hcnt <= hcnt + ONE;
              if (fall) hold_high <= hcnt;
            end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_team_06_clkmeasure.sv
// tb_team_06_clkmeasure: 16-bit and 4-bit instances checked every cycle against an interval model
module tb_team_06_clkmeasure;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0;
  logic sig_in = 1'b0;
  int checks = 0;
  int failures = 0;
  int p = 3;
  bit hist [0:8191];
  bit act [2];
  int prev [2];
  int e_per [2];
  int e_hi [2];
  bit e_val [2];
  bit e_lock [2];
  bit e_to [2];
  int mx [2] = '{65535, 15};
  int dut_nv = 0;
  int mod_nv = 0;
  team_06_clkmeasure_if #(.WIDTH(16)) b16();
  team_06_clkmeasure_if #(.WIDTH(4)) b4();
  assign b16.en = en;
  assign b16.sig_in = sig_in;
  assign b4.en = en;
  assign b4.sig_in = sig_in;
  team_06_clkmeasure #(.WIDTH(16)) u16 (.clk(clk), .nrst(nrst), .bus(b16));
  team_06_clkmeasure #(.WIDTH(4)) u4 (.clk(clk), .nrst(nrst), .bus(b4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0;
      prev[k] = -1;
      e_per[k] = 0;
      e_hi[k] = 0;
      e_val[k] = 1'b0;
      e_lock[k] = 1'b0;
      e_to[k] = 1'b0;
    end
  endtask
  task automatic model(input logic e);
    bit rise;
    int hi;
    rise = hist[p-2] && !hist[p-3];
    for (int k = 0; k < 2; k++) begin
      e_val[k] = 1'b0;
      if (!e) begin
        act[k] = 1'b0;
        prev[k] = -1;
        e_lock[k] = 1'b0;
      end else if (!act[k]) begin
        act[k] = 1'b1;
        prev[k] = -1;
      end else if (rise) begin
        if (prev[k] >= 0) begin
          hi = 0;
          for (int q = prev[k]; q < p; q++) hi += int'(hist[q-2]);
          e_per[k] = p - prev[k];
          e_hi[k] = hi > mx[k] ? mx[k] : hi;
          e_val[k] = 1'b1;
          e_lock[k] = 1'b1;
          e_to[k] = 1'b0;
        end
        prev[k] = p;
      end else if (prev[k] >= 0 && p - prev[k] == mx[k]) begin
        e_to[k] = 1'b1;
        e_lock[k] = 1'b0;
        prev[k] = -1;
      end
    end
  endtask
  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      int w;
      w = k ? 4 : 16;
      chk($sformatf("w%0d.valid@%0d", w, p), k ? 32'(b4.valid) : 32'(b16.valid), 32'(e_val[k]));
      chk($sformatf("w%0d.period@%0d", w, p), k ? 32'(b4.period) : 32'(b16.period), e_per[k]);
      chk($sformatf("w%0d.high_time@%0d", w, p), k ? 32'(b4.high_time) : 32'(b16.high_time), e_hi[k]);
      chk($sformatf("w%0d.locked@%0d", w, p), k ? 32'(b4.locked) : 32'(b16.locked), 32'(e_lock[k]));
      chk($sformatf("w%0d.timeout@%0d", w, p), k ? 32'(b4.timeout) : 32'(b16.timeout), 32'(e_to[k]));
    end
    dut_nv += int'(b16.valid);
    mod_nv += int'(e_val[0]);
  endtask
  task automatic step(input logic v, input logic e);
    sig_in = v;
    en = e;
    @(posedge clk);
    p++;
    hist[p] = v;
    model(e);
    #1;
    compare();
  endtask
  task automatic sq(input int hi, input int lo, input int n, input logic e = 1'b1);
    repeat (n) begin
      repeat (hi) step(1'b1, e);
      repeat (lo) step(1'b0, e);
    end
  endtask
  task automatic areset();
    #2 nrst = 1'b0;
    #1;
    model_reset();
    compare();
    hist[p] = 1'b0;
    hist[p-1] = 1'b0;
    hist[p-2] = 1'b0;
    #1 nrst = 1'b1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    nrst = 1'b1;
    sq(5, 5, 6);
    sq(3, 9, 6);
    repeat (3) step(1'b1, 1'b1);
    repeat (25) step(1'b0, 1'b1);
    sq(5, 5, 4);
    repeat (5) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    sq(5, 5, 4);
    sq(5, 5, 3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    sq(5, 5, 3);
    sq(5, 5, 3);
    repeat (2) step(1'b1, 1'b1);
    areset();
    repeat (3) step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    sq(5, 5, 4);
    repeat (60) begin
      int hi, lo;
      logic e;
      hi = $urandom_range(1, 20);
      lo = $urandom_range(1, 20);
      e = $urandom_range(0, 9) != 0;
      sq(hi, lo, 1, e);
      if ($urandom_range(0, 15) == 0) areset();
    end
    chk("valid_count16", dut_nv, mod_nv);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
